// File: rtl/gelato_warp_scheduler.sv
// gelato_warp_scheduler
//
// Fetch-stage warp scheduler. Each cycle it picks one warp whose split table
// offers a valid (pc, split_table_num). The pick is round-robin, starting at
// rr_ptr. The selected offer goes into a registered valid/ready output slot
// that feeds instruction fetch. A warp stays busy after its grant, so it cannot
// be offered again until issue/writeback returns an update for it.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   rdy             : global stall release; 0 freezes arbitration and the output
//   warp_valid      : per-warp offer valid
//   warp_pc         : per-warp pc, warp w at [w*PC_WIDTH +: PC_WIDTH]
//   warp_split      : per-warp split_table_num, same packing
//   warp_grant      : one-hot, combinational; the offer of warp w is consumed
//   fetch_valid     : registered request valid
//   fetch_ready     : fetch unit accepts the request
//   fetch_warp_id   : warp of the request
//   fetch_pc        : pc of the request
//   fetch_split     : split_table_num of the request
//   update_valid    : an update retires the outstanding fetch of a warp
//   update_warp_id  : warp being retired
//   busy_mask       : warps with an outstanding fetch
//   idle            : no busy warp and no pending request
module gelato_warp_scheduler #(
  parameter int WARP_NUM = 4,
  parameter int PC_WIDTH = 32,
  parameter int SPLIT_W  = 2,
  parameter int WID_W    = $clog2(WARP_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [WARP_NUM-1:0]          warp_valid,
  input  logic [WARP_NUM*PC_WIDTH-1:0] warp_pc,
  input  logic [WARP_NUM*SPLIT_W-1:0]  warp_split,
  output logic [WARP_NUM-1:0]          warp_grant,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [WID_W-1:0]             fetch_warp_id,
  output logic [PC_WIDTH-1:0]          fetch_pc,
  output logic [SPLIT_W-1:0]           fetch_split,
  input  logic                         update_valid,
  input  logic [WID_W-1:0]             update_warp_id,
  output logic [WARP_NUM-1:0]          busy_mask,
  output logic                         idle
);

  localparam logic [WID_W-1:0] PTR_ONE = WID_W'(1'b1);

  logic [WARP_NUM-1:0] busy_r;
  logic [WARP_NUM-1:0] busy_nxt_s;
  logic [WARP_NUM-1:0] eligible_s;
  logic [WARP_NUM-1:0] grant_s;
  logic [WARP_NUM-1:0] clr_mask_s;
  logic [WID_W-1:0]    rr_ptr_r;
  logic [WID_W-1:0]    rr_ptr_nxt_s;
  logic [WID_W-1:0]    winner_s;
  logic [WID_W-1:0]    idx_s;
  logic                found_s;
  logic                slot_free_s;
  logic                grant_en_s;

  logic                fetch_valid_r;
  logic                fetch_valid_nxt_s;
  logic [WID_W-1:0]    fetch_warp_id_r;
  logic [WID_W-1:0]    fetch_warp_id_nxt_s;
  logic [PC_WIDTH-1:0] fetch_pc_r;
  logic [PC_WIDTH-1:0] fetch_pc_nxt_s;
  logic [SPLIT_W-1:0]  fetch_split_r;
  logic [SPLIT_W-1:0]  fetch_split_nxt_s;

  assign eligible_s  = warp_valid & ~busy_r;
  assign slot_free_s = ~fetch_valid_r | fetch_ready;

  // Round-robin scan: first eligible warp at or after rr_ptr, wrapping.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    idx_s    = '0;
    for (int i = 0; i < WARP_NUM; i++) begin
      // WARP_NUM is a power of two, so the WID_W-bit add wraps for free.
      idx_s = rr_ptr_r + WID_W'(i);
      if (!found_s && eligible_s[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // Grant qualification. rst blocks grants so no split table pops an entry in
  // a cycle whose request is about to be discarded.
  always_comb begin
    grant_en_s = rdy & slot_free_s & found_s & ~rst;
    grant_s    = '0;
    if (grant_en_s) begin
      grant_s[winner_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Busy bookkeeping. Updates are applied even when rdy is low. An update to a
  // warp that is not busy clears nothing, so a set from a grant always wins.
  always_comb begin
    clr_mask_s = '0;
    if (update_valid) begin
      clr_mask_s[update_warp_id] = busy_r[update_warp_id];
    end else begin
      clr_mask_s = '0;
    end
    busy_nxt_s = (busy_r & ~clr_mask_s) | grant_s;
  end

  // Next value of the round-robin pointer and the output slot.
  always_comb begin
    rr_ptr_nxt_s        = rr_ptr_r;
    fetch_valid_nxt_s   = fetch_valid_r;
    fetch_warp_id_nxt_s = fetch_warp_id_r;
    fetch_pc_nxt_s      = fetch_pc_r;
    fetch_split_nxt_s   = fetch_split_r;
    if (grant_en_s) begin
      rr_ptr_nxt_s        = winner_s + PTR_ONE;
      fetch_valid_nxt_s   = 1'b1;
      fetch_warp_id_nxt_s = winner_s;
      fetch_pc_nxt_s      = warp_pc[winner_s*PC_WIDTH +: PC_WIDTH];
      fetch_split_nxt_s   = warp_split[winner_s*SPLIT_W +: SPLIT_W];
    end else if (rdy && fetch_valid_r && fetch_ready) begin
      // Handshake completes with nothing new to load: empty the slot, but
      // keep the payload.
      fetch_valid_nxt_s = 1'b0;
    end else begin
      // Stalled by rdy or by fetch_ready: the payload stays stable.
      fetch_valid_nxt_s = fetch_valid_r;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r          <= '0;
      rr_ptr_r        <= '0;
      fetch_valid_r   <= 1'b0;
      fetch_warp_id_r <= '0;
      fetch_pc_r      <= '0;
      fetch_split_r   <= '0;
    end else begin
      busy_r          <= busy_nxt_s;
      rr_ptr_r        <= rr_ptr_nxt_s;
      fetch_valid_r   <= fetch_valid_nxt_s;
      fetch_warp_id_r <= fetch_warp_id_nxt_s;
      fetch_pc_r      <= fetch_pc_nxt_s;
      fetch_split_r   <= fetch_split_nxt_s;
    end
  end

  assign warp_grant    = grant_s;
  assign fetch_valid   = fetch_valid_r;
  assign fetch_warp_id = fetch_warp_id_r;
  assign fetch_pc      = fetch_pc_r;
  assign fetch_split   = fetch_split_r;
  assign busy_mask     = busy_r;
  assign idle          = ~(|busy_r) & ~fetch_valid_r;

endmodule
